// File: rtl/rdc_pkg.sv
// Shared constants, record type and priority encoder for the RDC event logger.
// Core/event counts and timestamp width must match the RDC instance being monitored.
package rdc_pkg;

    localparam int N_CORES     = 2;
    localparam int CORE_EVENTS = 4;
    localparam int TS_WIDTH    = 32;
    localparam int N_COUNTERS  = N_CORES * CORE_EVENTS;
    localparam int IDX_W       = $clog2(N_COUNTERS);

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic [TS_WIDTH-1:0] ts;
    } rdc_rec_t;

    // Index of the lowest set bit; 0 when none is set (callers gate on |vec).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_COUNTERS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_COUNTERS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rdc_rec_fifo.sv
// Synchronous record FIFO with registered storage, simultaneous push/pop and a level count.
// The head record is read directly from the storage registers (no fall-through).
module rdc_rec_fifo
    import rdc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  rdc_rec_t               din_i,
    input  logic                   pop_i,
    output rdc_rec_t               head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    rdc_rec_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW + 1)'(DEPTH));
    assign level_o = count;
    assign head_o  = mem[rd_ptr];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset as well, so the head reads 0 out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/rdc_event_logger.sv
// Turns rising edges of the RDC interruption vector into an ordered {index, timestamp} log
// with a level interrupt while any record is pending or undelivered.
module rdc_event_logger
    import rdc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic [N_COUNTERS-1:0]       interruption_vector_i,
    output logic                        rec_valid_o,
    input  logic                        rec_ready_i,
    output logic [IDX_W-1:0]            rec_index_o,
    output logic [TS_WIDTH-1:0]         rec_timestamp_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        irq_o,
    output logic                        overflow_o
);

    logic [TS_WIDTH-1:0]   ts;
    logic [N_COUNTERS-1:0] prev;
    logic [N_COUNTERS-1:0] pending;
    logic [N_COUNTERS-1:0] rise;
    logic [N_COUNTERS-1:0] push_sel;
    logic [TS_WIDTH-1:0]   ts_cap [N_COUNTERS];
    logic                  overflow;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic [IDX_W-1:0]      push_idx;
    rdc_rec_t              push_rec;
    rdc_rec_t              head;

    assign rise     = interruption_vector_i & ~prev & {N_COUNTERS{enable_i}};
    assign pop      = rec_valid_o & rec_ready_i;
    assign push_idx = lowest_set(pending);
    assign push     = (|pending) & (~fifo_full | pop);
    assign push_rec = '{idx: push_idx, ts: ts_cap[push_idx]};

    always_comb begin
        // NOTE: default first so no path leaves push_sel unassigned (no latch).
        push_sel = '0;
        if (push) push_sel[push_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts       <= '0;
            prev     <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < N_COUNTERS; k++) ts_cap[k] <= '0;
        end else if (clear_i) begin
            // prev keeps tracking the vector so bits held high across a clear stay quiet.
            ts       <= '0;
            prev     <= interruption_vector_i;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            ts   <= enable_i ? ts + TS_WIDTH'(1) : ts;
            prev <= interruption_vector_i;
            for (int k = 0; k < N_COUNTERS; k++) begin
                if (rise[k] && (!pending[k] || push_sel[k])) begin
                    pending[k] <= 1'b1;
                    ts_cap[k]  <= ts;
                end else if (rise[k]) begin
                    overflow <= 1'b1;
                end else if (push_sel[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    rdc_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .din_i   (push_rec),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level_o)
    );

    assign rec_valid_o     = ~fifo_empty;
    assign rec_index_o     = head.idx;
    assign rec_timestamp_o = head.ts;
    assign irq_o           = (|pending) | ~fifo_empty;
    assign overflow_o      = overflow;

endmodule
